melody_scheduler: RTL and testbench

//  Sequences and arbitrates the tone datapath that feeds buzzerControl (note_div, posVol, negVol).

---
 rtl/audio_pkg.sv | 29 ++
 rtl/beat_timer.sv | 40 ++++
 rtl/melody_scheduler.sv | 171 +++++++++++++++++
 tb/tb_melody_scheduler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared constants and types for the tone datapath: note dividers,
// ROM word layout, volume widths and the melody scheduler state encoding.
package audio_pkg;

    localparam int DIV_W   = 22;
    localparam int BEATS_W = 4;
    localparam int ROM_W   = DIV_W + BEATS_W;
    localparam int VOL_W   = 4;
    localparam int AMP_W   = 16;
    localparam int ADDR_W  = 5;

    localparam logic [DIV_W-1:0] DIV_DO   = 22'd191571;
    localparam logic [DIV_W-1:0] DIV_RE   = 22'd170648;
    localparam logic [DIV_W-1:0] DIV_MI   = 22'd151515;
    localparam logic [DIV_W-1:0] DIV_MUTE = 22'd1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_PLAY  = 2'd2,
        ST_PAUSE = 2'd3
    } sched_state_t;

    // Amplitude for a volume exponent: one power-of-two step per level.
    function automatic logic [AMP_W-1:0] vol_amplitude(input logic [VOL_W-1:0] level);
        return {{(AMP_W-1){1'b0}}, 1'b1} << level;
    endfunction

endpackage

// File: rtl/beat_timer.sv
// Free-running period counter with enable and clear; emits a one-cycle
// tick on the cycle where the count wraps from PERIOD-1 back to 0.
module beat_timer #(
    parameter int PERIOD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, otherwise advance and wrap while enabled.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    assign tick = en && !clr && (count_q == LAST);

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/melody_scheduler.sv
// Melody sequencer and tone arbiter in front of buzzerControl. Walks the
// melody ROM one note per beat count, lets a held key override the note,
// and owns the volume exponent and the mute-to-silence rule.
module melody_scheduler
    import audio_pkg::*;
#(
    parameter int                 BEAT_DIV = 12_500_000,
    parameter int                 SONG_LEN = 32,
    parameter logic [DIV_W-1:0]   MUTE_DIV = DIV_MUTE,
    parameter logic [VOL_W-1:0]   VOL_RST  = 4'd10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  play_pulse,
    input  logic                  stop_pulse,
    input  logic                  key_valid,
    input  logic [DIV_W-1:0]      key_div,
    input  logic                  vol_up_pulse,
    input  logic                  vol_dn_pulse,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [ROM_W-1:0]      rom_data,
    output logic [DIV_W-1:0]      note_div,
    output logic [AMP_W-1:0]      pos_vol,
    output logic [AMP_W-1:0]      neg_vol,
    output logic [1:0]            state,
    output logic [VOL_W-1:0]      vol_level
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);
    localparam logic [VOL_W-1:0]  VOL_MAX   = '1;

    sched_state_t        state_q, state_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [DIV_W-1:0]    cur_div_q, cur_div_d;
    logic [BEATS_W-1:0]  beats_left_q, beats_left_d;
    logic [VOL_W-1:0]    vol_level_q, vol_level_d;
    logic [DIV_W-1:0]    note_div_q, note_div_d;
    logic [AMP_W-1:0]    pos_vol_q, pos_vol_d;
    logic [AMP_W-1:0]    neg_vol_q, neg_vol_d;

    logic [DIV_W-1:0]    rom_div;
    logic [BEATS_W-1:0]  rom_beats;
    logic [DIV_W-1:0]    melody_div;
    logic [DIV_W-1:0]    sel_div;
    logic                timer_en;
    logic                timer_clr;
    logic                beat_tick;

    assign rom_div   = rom_data[ROM_W-1:BEATS_W];
    assign rom_beats = rom_data[BEATS_W-1:0];

    // The beat counter only runs in PLAY; a pause request, a stop or a held
    // key freezes it, and IDLE/LOAD/stop restart it from zero.
    assign timer_en  = (state_q == ST_PLAY) && !play_pulse && !stop_pulse && !key_valid;
    assign timer_clr = stop_pulse || (state_q == ST_IDLE) || (state_q == ST_LOAD);

    beat_timer #(
        .PERIOD (BEAT_DIV)
    ) u_beat_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (timer_en),
        .clr   (timer_clr),
        .tick  (beat_tick)
    );

    // Sequencer next state: stop overrides everything, LOAD latches the
    // ROM word, PLAY counts beats down and advances to the next word.
    always_comb begin
        state_d      = state_q;
        rom_addr_d   = rom_addr_q;
        cur_div_d    = cur_div_q;
        beats_left_d = beats_left_q;
        if (stop_pulse) begin
            state_d      = ST_IDLE;
            rom_addr_d   = '0;
            beats_left_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rom_addr_d   = '0;
                    beats_left_d = '0;
                    if (play_pulse) begin
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cur_div_d    = rom_div;
                    beats_left_d = rom_beats;
                    if (rom_beats == '0) begin
                        state_d    = ST_IDLE;
                        rom_addr_d = '0;
                    end else begin
                        state_d = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (play_pulse) begin
                        state_d = ST_PAUSE;
                    end else if (beat_tick) begin
                        beats_left_d = beats_left_q - 1'b1;
                        if (beats_left_q == {{(BEATS_W-1){1'b0}}, 1'b1}) begin
                            rom_addr_d = (rom_addr_q == LAST_ADDR) ? '0 : rom_addr_q + 1'b1;
                            state_d    = ST_LOAD;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (play_pulse) begin
                        state_d = ST_PLAY;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Volume exponent: saturating steps, conflicting requests cancel.
    always_comb begin
        vol_level_d = vol_level_q;
        if (vol_up_pulse && !vol_dn_pulse && (vol_level_q != VOL_MAX)) begin
            vol_level_d = vol_level_q + 1'b1;
        end else if (vol_dn_pulse && !vol_up_pulse && (vol_level_q != '0)) begin
            vol_level_d = vol_level_q - 1'b1;
        end
    end

    // Tone selection: key overrides the melody, mute divider forces silence.
    always_comb begin
        melody_div = (state_q == ST_PLAY) ? cur_div_q : MUTE_DIV;
        sel_div    = key_valid ? key_div : melody_div;
        note_div_d = sel_div;
        pos_vol_d  = (sel_div == MUTE_DIV) ? '0 : vol_amplitude(vol_level_q);
        neg_vol_d  = ~pos_vol_d + {{(AMP_W-1){1'b0}}, 1'b1};
    end

    // State, sequencing and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rom_addr_q   <= '0;
            cur_div_q    <= MUTE_DIV;
            beats_left_q <= '0;
            vol_level_q  <= VOL_RST;
            note_div_q   <= MUTE_DIV;
            pos_vol_q    <= '0;
            neg_vol_q    <= '0;
        end else begin
            state_q      <= state_d;
            rom_addr_q   <= rom_addr_d;
            cur_div_q    <= cur_div_d;
            beats_left_q <= beats_left_d;
            vol_level_q  <= vol_level_d;
            note_div_q   <= note_div_d;
            pos_vol_q    <= pos_vol_d;
            neg_vol_q    <= neg_vol_d;
        end
    end

    // The ROM has one cycle of read latency, so it is addressed with the
    // next address; the word for a new note is then ready in its LOAD cycle.
    assign rom_addr  = rom_addr_d;
    assign note_div  = note_div_q;
    assign pos_vol   = pos_vol_q;
    assign neg_vol   = neg_vol_q;
    assign state     = state_q;
    assign vol_level = vol_level_q;

endmodule

// File: tb/tb_melody_scheduler.sv
// Self-checking bench for melody_scheduler with a short four-word song.
module tb_melody_scheduler;
    import audio_pkg::*;

    localparam int BEAT_DIV = 4;
    localparam int SONG_LEN = 4;
    localparam logic [21:0] MUTE = 22'd1000;
    localparam int M_IDLE = 0, M_LOAD = 1, M_PLAY = 2, M_PAUSE = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        play_pulse = 1'b0, stop_pulse = 1'b0;
    logic        key_valid = 1'b0;
    logic [21:0] key_div = '0;
    logic        vol_up_pulse = 1'b0, vol_dn_pulse = 1'b0;
    logic [4:0]  rom_addr;
    logic [25:0] rom_data = '0;
    logic [21:0] note_div;
    logic [15:0] pos_vol, neg_vol;
    logic [1:0]  state;
    logic [3:0]  vol_level;

    logic [25:0] rom_mem [0:31];

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    melody_scheduler #(
        .BEAT_DIV (BEAT_DIV),
        .SONG_LEN (SONG_LEN),
        .MUTE_DIV (MUTE),
        .VOL_RST  (4'd10)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .play_pulse   (play_pulse),
        .stop_pulse   (stop_pulse),
        .key_valid    (key_valid),
        .key_div      (key_div),
        .vol_up_pulse (vol_up_pulse),
        .vol_dn_pulse (vol_dn_pulse),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .note_div     (note_div),
        .pos_vol      (pos_vol),
        .neg_vol      (neg_vol),
        .state        (state),
        .vol_level    (vol_level)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 32; i++) rom_mem[i] = '0;
        rom_mem[0] = {DIV_DO, 4'd2};
        rom_mem[1] = {DIV_RE, 4'd1};
        rom_mem[2] = {DIV_MI, 4'd1};
    end

    // Synchronous ROM with one cycle of read latency.
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    // Behavioural model: a note lasts beats*BEAT_DIV counted PLAY cycles.
    int          m_mode = M_IDLE, m_idx = 0, m_elapsed = 0, m_len = 0, m_vol = 10;
    logic [21:0] m_div = MUTE;
    logic [31:0] exp_note = 32'(MUTE), exp_pos = 0, exp_neg = 0;
    logic [21:0] m_sel;

    assign m_sel = key_valid ? key_div : ((m_mode == M_PLAY) ? m_div : MUTE);

    function automatic logic [31:0] model_pos(input logic [21:0] sel, input int vol);
        if (sel == MUTE) return 32'd0;
        return 32'd1 << vol;
    endfunction

    function automatic logic [31:0] model_neg(input logic [21:0] sel, input int vol);
        logic [31:0] p;
        p = model_pos(sel, vol);
        if (p == 0) return 32'd0;
        return 32'h10000 - p;
    endfunction

    // Model state advance, one step per clock, reset asynchronously.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= M_IDLE; m_idx <= 0; m_elapsed <= 0; m_len <= 0;
            m_div <= MUTE; m_vol <= 10;
            exp_note <= 32'(MUTE); exp_pos <= 0; exp_neg <= 0;
        end else begin
            exp_note <= 32'(m_sel);
            exp_pos  <= model_pos(m_sel, m_vol);
            exp_neg  <= model_neg(m_sel, m_vol);
            if (vol_up_pulse && !vol_dn_pulse && m_vol < 15) m_vol <= m_vol + 1;
            else if (vol_dn_pulse && !vol_up_pulse && m_vol > 0) m_vol <= m_vol - 1;
            if (stop_pulse) begin
                m_mode <= M_IDLE; m_idx <= 0; m_elapsed <= 0;
            end else begin
                case (m_mode)
                    M_IDLE:  if (play_pulse) m_mode <= M_LOAD;
                    M_LOAD: begin
                        if (rom_mem[m_idx][3:0] == 4'd0) begin
                            m_mode <= M_IDLE; m_idx <= 0;
                        end else begin
                            m_div     <= rom_mem[m_idx][25:4];
                            m_len     <= BEAT_DIV * int'(rom_mem[m_idx][3:0]);
                            m_elapsed <= 0;
                            m_mode    <= M_PLAY;
                        end
                    end
                    M_PLAY: begin
                        if (play_pulse) m_mode <= M_PAUSE;
                        else if (!key_valid) begin
                            if (m_elapsed == m_len - 1) begin
                                m_idx  <= (m_idx + 1) % SONG_LEN;
                                m_mode <= M_LOAD;
                            end else begin
                                m_elapsed <= m_elapsed + 1;
                            end
                        end
                    end
                    M_PAUSE: if (play_pulse) m_mode <= M_PLAY;
                    default: m_mode <= M_IDLE;
                endcase
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, actual, actual, expected, expected, $time);
        end
    endtask

    // Every-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            checkOutput("note_div", 32'(note_div), exp_note);
            checkOutput("pos_vol", 32'(pos_vol), exp_pos);
            checkOutput("neg_vol", 32'(neg_vol), exp_neg);
            checkOutput("state", 32'(state), 32'(m_mode));
            checkOutput("vol_level", 32'(vol_level), 32'(m_vol));
            if (m_mode == M_IDLE) checkOutput("rom_addr_idle", 32'(rom_addr), 32'd0);
        end
    end

    task automatic applyStimulus(input logic play, input logic stop, input logic up, input logic dn);
        @(negedge clk); #1;
        play_pulse = play; stop_pulse = stop; vol_up_pulse = up; vol_dn_pulse = dn;
        @(negedge clk); #1;
        play_pulse = 1'b0; stop_pulse = 1'b0; vol_up_pulse = 1'b0; vol_dn_pulse = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    int cnt_do, cnt_re, cnt_mi;

    initial begin
        #2 rst_n = 1'b0;
        waitCycles(2);
        checkOutput("reset_state", 32'(state), 32'd0);
        checkOutput("reset_note_div", 32'(note_div), 32'd1000);
        checkOutput("reset_pos_vol", 32'(pos_vol), 32'd0);
        checkOutput("reset_neg_vol", 32'(neg_vol), 32'd0);
        checkOutput("reset_vol_level", 32'(vol_level), 32'd10);
        checkOutput("reset_rom_addr", 32'(rom_addr), 32'd0);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        waitCycles(2);

        $display("[TB] test 1: full song");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t1_load_state", 32'(state), 32'd1);
        cnt_do = 0; cnt_re = 0; cnt_mi = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (note_div == DIV_DO) cnt_do++;
            if (note_div == DIV_RE) cnt_re++;
            if (note_div == DIV_MI) cnt_mi++;
        end
        checkOutput("t1_do_cycles", 32'(cnt_do), 32'd8);
        checkOutput("t1_re_cycles", 32'(cnt_re), 32'd4);
        checkOutput("t1_mi_cycles", 32'(cnt_mi), 32'd4);
        checkOutput("t1_end_state", 32'(state), 32'd0);
        checkOutput("t1_end_note_div", 32'(note_div), 32'd1000);
        checkOutput("t1_end_pos_vol", 32'(pos_vol), 32'd0);
        checkOutput("t1_end_rom_addr", 32'(rom_addr), 32'd0);

        $display("[TB] test 2: pause and resume");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitCycles(3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitCycles(2);
        checkOutput("t2_pause_state", 32'(state), 32'd3);
        checkOutput("t2_pause_pos_vol", 32'(pos_vol), 32'd0);
        waitCycles(20);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        cnt_do = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (note_div == DIV_DO) cnt_do++;
        end
        checkOutput("t2_do_after_resume", 32'(cnt_do), 32'd5);
        waitCycles(20);
        checkOutput("t2_end_state", 32'(state), 32'd0);

        $display("[TB] test 3: key override mid-RE");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        cnt_re = 0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (note_div == DIV_RE) cnt_re++;
        end
        #1 key_valid = 1'b1; key_div = DIV_MI;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (note_div == DIV_RE) cnt_re++;
            if (i == 5) begin
                checkOutput("t3_key_note_div", 32'(note_div), 32'(DIV_MI));
                checkOutput("t3_key_state", 32'(state), 32'd2);
            end
        end
        #1 key_valid = 1'b0; key_div = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (note_div == DIV_RE) cnt_re++;
        end
        checkOutput("t3_re_total_cycles", 32'(cnt_re), 32'd4);

        $display("[TB] test 4: stop beats play");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitCycles(5);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("t4_state", 32'(state), 32'd0);
        checkOutput("t4_rom_addr", 32'(rom_addr), 32'd0);
        waitCycles(2);
        checkOutput("t4_note_div", 32'(note_div), 32'd1000);

        $display("[TB] test 5: volume");
        @(negedge clk); #1 key_valid = 1'b1; key_div = DIV_DO;
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        waitCycles(1);
        checkOutput("t5_vol_max", 32'(vol_level), 32'd15);
        checkOutput("t5_pos_max", 32'(pos_vol), 32'h8000);
        checkOutput("t5_neg_max", 32'(neg_vol), 32'h8000);
        repeat (16) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        waitCycles(1);
        checkOutput("t5_vol_min", 32'(vol_level), 32'd0);
        checkOutput("t5_pos_min", 32'(pos_vol), 32'd1);
        checkOutput("t5_neg_min", 32'(neg_vol), 32'hFFFF);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        waitCycles(1);
        checkOutput("t5_vol_both", 32'(vol_level), 32'd3);
        checkOutput("t5_pos_both", 32'(pos_vol), 32'd8);
        checkOutput("t5_neg_both", 32'(neg_vol), 32'hFFF8);
        #1 key_valid = 1'b0; key_div = '0;

        $display("[TB] test 6: asynchronous reset mid-PLAY");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitCycles(6);
        checkOutput("t6_pre_state", 32'(state), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_state", 32'(state), 32'd0);
        checkOutput("t6_note_div", 32'(note_div), 32'd1000);
        checkOutput("t6_pos_vol", 32'(pos_vol), 32'd0);
        checkOutput("t6_neg_vol", 32'(neg_vol), 32'd0);
        checkOutput("t6_vol_level", 32'(vol_level), 32'd10);
        checkOutput("t6_rom_addr", 32'(rom_addr), 32'd0);
        waitCycles(1);
        #1 rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitCycles(25);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
